// File: rtl/sram_responder.sv
// sram_responder: board-side responder for the UDLX external SRAM pins.
//   Decodes the active-low strobes, stores 16-bit words with byte-lane masking,
//   and returns read data through a RD_LATENCY-deep pipeline.
//   Optional feature macro: SRAM_STATS_EN (saturating read/write counters).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   sram_ce_n/we_n/oe_n/ub_n/lb_n   active-low chip, write, output, upper/lower lane enables
//   sram_addr, sram_wr_data         word address (low ADDR_WIDTH bits used), write data
//   sram_rd_data, rd_valid          read result and its one-cycle valid pulse
//   rd_count, wr_count              accepted read/write counts (zero without SRAM_STATS_EN)
module sram_responder #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 10,
    parameter int ADDR_IN_WIDTH = 32,
    parameter int RD_LATENCY    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sram_ce_n,
    input  logic                     sram_we_n,
    input  logic                     sram_oe_n,
    input  logic                     sram_ub_n,
    input  logic                     sram_lb_n,
    input  logic [ADDR_IN_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0]    sram_wr_data,
    output logic [DATA_WIDTH-1:0]    sram_rd_data,
    output logic                     rd_valid,
    output logic [15:0]              rd_count,
    output logic [15:0]              wr_count
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t                  r_state, w_next;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [1:0]              w_lanes;
    logic                    w_unused;
    logic [DATA_WIDTH-1:0]   r_mem [2**ADDR_WIDTH];
    logic                    r_pv  [RD_LATENCY];
    logic [1:0]              r_pm  [RD_LATENCY];
    logic [DATA_WIDTH-1:0]   r_pd  [RD_LATENCY];

    assign w_addr  = sram_addr[ADDR_WIDTH-1:0];
    assign w_lanes = {~sram_ub_n, ~sram_lb_n};

    // Write takes priority over a simultaneously low oe_n.
    always_comb begin
        w_next = sram_ce_n ? S_IDLE : !sram_we_n ? S_WR : !sram_oe_n ? S_RD : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_next == S_WR) begin
            if (w_lanes[1]) r_mem[w_addr][15:8] <= sram_wr_data[15:8];
            if (w_lanes[0]) r_mem[w_addr][7:0]  <= sram_wr_data[7:0];
        end
    end

    // Read data is captured on the sampling edge, so a later write to the
    // same address cannot disturb a read already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pm[i] <= 2'b00;
                r_pd[i] <= '0;
            end
            rd_valid     <= 1'b0;
            sram_rd_data <= '0;
        end else begin
            r_pv[0] <= (w_next == S_RD);
            r_pm[0] <= w_lanes;
            r_pd[0] <= r_mem[w_addr];
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pm[i] <= r_pm[i-1];
                r_pd[i] <= r_pd[i-1];
            end
            rd_valid <= r_pv[RD_LATENCY-1];
            if (r_pv[RD_LATENCY-1])
                sram_rd_data <= {r_pm[RD_LATENCY-1][1] ? r_pd[RD_LATENCY-1][15:8] : 8'h00,
                                 r_pm[RD_LATENCY-1][0] ? r_pd[RD_LATENCY-1][7:0]  : 8'h00};
        end
    end

`ifdef SRAM_STATS_EN
    logic [15:0] r_rd_count, r_wr_count;

    // Counts follow the registered command state, one cycle behind the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (r_state == S_RD && r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
            if (r_state == S_WR && r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
    assign w_unused = ^sram_addr[ADDR_IN_WIDTH-1:ADDR_WIDTH];
`else
    assign rd_count = 16'h0000;
    assign wr_count = 16'h0000;
    assign w_unused = ^{sram_addr[ADDR_IN_WIDTH-1:ADDR_WIDTH], r_state};
`endif
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized scoreboard bench for sram_responder.
module tb_sram_responder;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n, ce_n, we_n, oe_n, ub_n, lb_n;
    logic [31:0] addr;
    logic [15:0] wd, rd_data, rd_count, wr_count;
    logic        rd_valid;

    always #5 clk = ~clk;

    sram_responder #(.RD_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .sram_ce_n(ce_n), .sram_we_n(we_n), .sram_oe_n(oe_n),
        .sram_ub_n(ub_n), .sram_lb_n(lb_n), .sram_addr(addr), .sram_wr_data(wd),
        .sram_rd_data(rd_data), .rd_valid(rd_valid), .rd_count(rd_count), .wr_count(wr_count)
    );

    typedef struct {logic [15:0] d; int due;} exp_t;

    exp_t        q[$];
    logic [15:0] mdl [1024];
    logic [15:0] last = 16'h0;
    int          n_chk = 0, n_fail = 0, edges = 0, rd_n = 0, wr_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every cycle rd_valid must match the scoreboard's due time;
    // data is compared on a pulse and must hold otherwise.
    always @(posedge clk) begin : mon
        exp_t e;
        logic ev;
        #1;
        edges++;
        if (!rst_n) last = 16'h0;
        else begin
            ev = q.size() > 0 && q[0].due == edges;
            chk("rd_valid", 32'(rd_valid), 32'(ev));
            if (rd_valid && ev) begin
                e = q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e.d));
                last = rd_data;
            end else if (!rd_valid)
                chk("rd_data_hold", 32'(rd_data), 32'(last));
        end
    end

    // kind: 0 idle (ce_n high), 1 write, 2 read, 3 idle with ce_n low.
    task automatic op(input int kind, input logic [31:0] a, input logic [15:0] d,
                      input logic ub, input logic lb, input logic oe);
        int w = int'(a % 32'd1024);
        ce_n = (kind == 0);
        we_n = (kind == 1) ? 1'b0 : (kind == 0) ? 1'($urandom) : 1'b1;
        oe_n = (kind == 2) ? 1'b0 : (kind == 3) ? 1'b1 : oe;
        ub_n = ub; lb_n = lb; addr = a; wd = d;
        if (kind == 1) begin
            if (!ub) mdl[w][15:8] = d[15:8];
            if (!lb) mdl[w][7:0]  = d[7:0];
            wr_n++;
        end
        if (kind == 2) begin
            q.push_back('{d: {ub ? 8'h00 : mdl[w][15:8], lb ? 8'h00 : mdl[w][7:0]}, due: edges + 1 + LAT});
            rd_n++;
        end
        @(negedge clk);
    endtask

    task automatic chk_counts();
`ifdef SRAM_STATS_EN
        chk("rd_count", 32'(rd_count), 32'(rd_n));
        chk("wr_count", 32'(wr_count), 32'(wr_n));
`else
        chk("rd_count", 32'(rd_count), 32'd0);
        chk("wr_count", 32'(wr_count), 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
        addr = '0; wd = '0;
        repeat (3) @(negedge clk);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_count", 32'(rd_count), 32'd0);
        chk("reset_wr_count", 32'(wr_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) op(1, 32'(i), 16'($urandom), 1'b0, 1'b0, 1'b1);
        op(1, 32'h012, 16'hA5C3, 1'b0, 1'b0, 1'b1);
        op(2, 32'h012, 16'h0, 1'b0, 1'b0, 1'b0);
        op(1, 32'h020, 16'h1234, 1'b0, 1'b0, 1'b1);
        op(1, 32'h020, 16'hFF00, 1'b0, 1'b1, 1'b1);
        op(2, 32'h020, 16'h0, 1'b1, 1'b0, 1'b0);
        op(2, 32'h020, 16'h0, 1'b0, 1'b0, 1'b0);
        op(1, 32'h405, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        op(0, 32'h0, 16'h0, 1'b1, 1'b1, 1'b1);
        op(2, 32'h005, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) op(2, 32'(i), 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            int k = int'($urandom_range(0, 5));
            logic [31:0] a = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) + 32'($urandom_range(0, 3) << 10)
                                                  : $urandom;
            op(k > 3 ? 2 : k, a, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        op(0, 32'h0, 16'h0, 1'b1, 1'b1, 1'b1);
        repeat (LAT + 3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk_counts();
        op(2, 32'h012, 16'h0, 1'b0, 1'b0, 1'b0);
        op(0, 32'h0, 16'h0, 1'b1, 1'b1, 1'b1);
        op(0, 32'h0, 16'h0, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        q.delete();
        rd_n = 0; wr_n = 0;
        repeat (2) @(negedge clk);
        chk("midreset_rd_data", 32'(rd_data), 32'd0);
        chk("midreset_rd_valid", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        chk_counts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
